prog_oscillator: RTL and testbench

- Synchronous, parametrised successor to the team's gated ring oscillator.
- Produces a square wave from a system clock. HIGH and LOW phase lengths are programmable in clock cycles.
- An enable gates the output, as in the ring oscillator, and a burst mode emits exactly N periods and then stops.
- Used as a tone/blink/clock-enable source for lab datapaths. No combinational loops and no delay-based timing.

---
 rtl/prog_oscillator_if.sv | 27 ++
 rtl/prog_oscillator.sv | 123 ++++++++++++
 tb/tb_prog_oscillator.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/prog_oscillator_if.sv
// Control and status bundle for prog_oscillator.
// master drives the configuration; slave is the oscillator core.
interface prog_oscillator_if #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned BURST_W = 8
);
  logic               en;
  logic [1:0]         mode;
  logic [CNT_W-1:0]   high_cnt;
  logic [CNT_W-1:0]   low_cnt;
  logic [BURST_W-1:0] burst_len;
  logic               start;
  logic               out;
  logic               busy;
  logic               period_tick;
  logic               done;

  modport master (
    output en, mode, high_cnt, low_cnt, burst_len, start,
    input  out, busy, period_tick, done
  );

  modport slave (
    input  en, mode, high_cnt, low_cnt, burst_len, start,
    output out, busy, period_tick, done
  );
endinterface

// File: rtl/prog_oscillator.sv
// Synchronous programmable square-wave generator with free-run and N-period burst modes.
// HIGH/LOW lengths are relatched at each HIGH entry so a period never changes shape mid-flight.
module prog_oscillator #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned BURST_W  = 8,
  parameter logic        IDLE_LVL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  prog_oscillator_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   h_q;
  logic [CNT_W-1:0]   l_q;
  logic [BURST_W-1:0] rem_q;
  logic               burst_q;
  logic               out_q;
  logic               busy_q;
  logic               tick_q;
  logic               done_q;

  logic [CNT_W-1:0]   h_eff;
  logic [CNT_W-1:0]   l_eff;
  logic               launch_free;
  logic               launch_burst;
  logic               zero_burst;

  // Zero-length phases are promoted to one cycle.
  always_comb begin
    h_eff        = (bus.high_cnt == '0) ? CNT_W'(1) : bus.high_cnt;
    l_eff        = (bus.low_cnt == '0) ? CNT_W'(1) : bus.low_cnt;
    launch_free  = bus.en && (bus.mode == 2'b00);
    launch_burst = bus.en && (bus.mode == 2'b01) && bus.start && (bus.burst_len != '0);
    zero_burst   = bus.en && (bus.mode == 2'b01) && bus.start && (bus.burst_len == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      h_q     <= '0;
      l_q     <= '0;
      rem_q   <= '0;
      burst_q <= 1'b0;
      out_q   <= IDLE_LVL;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      if (!bus.en) begin
        // Abort: no done, no tick, burst discarded.
        state_q <= StIdle;
        out_q   <= IDLE_LVL;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (launch_free || launch_burst) begin
              state_q <= StHigh;
              out_q   <= 1'b1;
              busy_q  <= 1'b1;
              burst_q <= bus.mode[0];
              rem_q   <= bus.burst_len;
              h_q     <= h_eff;
              l_q     <= l_eff;
              cnt_q   <= h_eff - CNT_W'(1);
            end else if (zero_burst) begin
              done_q <= 1'b1;
            end
          end
          StHigh: begin
            if (cnt_q == '0) begin
              state_q <= StLow;
              out_q   <= 1'b0;
              cnt_q   <= l_q - CNT_W'(1);
              tick_q  <= (l_q == CNT_W'(1));
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          StLow: begin
            if (cnt_q != '0) begin
              cnt_q  <= cnt_q - CNT_W'(1);
              tick_q <= (cnt_q == CNT_W'(1));
            end else if (burst_q && (rem_q == BURST_W'(1))) begin
              state_q <= StIdle;
              out_q   <= IDLE_LVL;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              rem_q   <= '0;
            end else begin
              if (burst_q) begin
                rem_q <= rem_q - BURST_W'(1);
              end
              state_q <= StHigh;
              out_q   <= 1'b1;
              h_q     <= h_eff;
              l_q     <= l_eff;
              cnt_q   <= h_eff - CNT_W'(1);
            end
          end
          default: begin
            state_q <= StIdle;
            out_q   <= IDLE_LVL;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.out         = out_q;
  assign bus.busy        = busy_q;
  assign bus.period_tick = tick_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_prog_oscillator.sv
// Directed bench for prog_oscillator; expected {out,busy,period_tick,done} goes through a queue.
module tb_prog_oscillator;

  localparam int unsigned CW = 4;
  localparam int unsigned BW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prog_oscillator_if #(.CNT_W(CW), .BURST_W(BW)) bus ();

  prog_oscillator #(
    .CNT_W   (CW),
    .BURST_W (BW),
    .IDLE_LVL(1'b0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] sb[$];

  task automatic compare_pop(input string tag);
    logic [3:0] obs;
    logic [3:0] exp_v;
    obs   = {bus.out, bus.busy, bus.period_tick, bus.done};
    exp_v = sb.pop_front();
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed {out,busy,tick,done}=%b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic expect_now(input logic [3:0] e, input string tag);
    sb.push_back(e);
    compare_pop(tag);
  endtask

  task automatic step(input logic [3:0] e, input string tag);
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_pop(tag);
  endtask

  // Expected output for cycle i (counted from launch) of a running period h/l.
  function automatic logic [3:0] fr(input int i, input int h, input int l);
    int p;
    p = i % (h + l);
    if (p < h) return 4'b1100;
    else if (p == h + l - 1) return 4'b0110;
    else return 4'b0100;
  endfunction

  initial begin
    bus.en        = 1'b0;
    bus.mode      = 2'b00;
    bus.high_cnt  = '0;
    bus.low_cnt   = '0;
    bus.burst_len = '0;
    bus.start     = 1'b0;
    #2;
    expect_now(4'b0000, "reset_values");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'b0000, "idle_en_low");

    // Free-run 3/2
    bus.en = 1'b1; bus.high_cnt = 4'd3; bus.low_cnt = 4'd2;
    for (int i = 0; i < 20; i++) step(fr(i, 3, 2), "freerun_3_2");
    bus.en = 1'b0;
    step(4'b0000, "abort_freerun");

    // Reconfigure mid-HIGH: 4/4 period completes, then 2/6
    bus.en = 1'b1; bus.high_cnt = 4'd4; bus.low_cnt = 4'd4;
    for (int i = 0; i < 24; i++) begin
      if (i == 2) begin
        bus.high_cnt = 4'd2; bus.low_cnt = 4'd6;
      end
      step((i < 8) ? fr(i, 4, 4) : fr(i - 8, 2, 6), "reconfig");
    end
    bus.en = 1'b0;
    step(4'b0000, "abort_reconfig");

    // Zero-length phases behave as 1/1
    bus.en = 1'b1; bus.high_cnt = '0; bus.low_cnt = '0;
    for (int i = 0; i < 4; i++) step(fr(i, 1, 1), "zero_phase");
    bus.en = 1'b0;
    step(4'b0000, "abort_zero_phase");

    // Zero-length burst: done only
    bus.en = 1'b1; bus.mode = 2'b01; bus.burst_len = '0; bus.start = 1'b1;
    step(4'b0001, "zero_burst_done");
    bus.start = 1'b0;
    step(4'b0000, "zero_burst_after");

    // Burst of 4 x (1/1), with an ignored second start
    bus.high_cnt = 4'd1; bus.low_cnt = 4'd1; bus.burst_len = 3'd4; bus.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) bus.start = 1'b0;
      if (i == 3) bus.start = 1'b1;
      if (i == 4) bus.start = 1'b0;
      step(fr(i, 1, 1), "burst4");
    end
    step(4'b0001, "burst4_done");
    for (int i = 0; i < 3; i++) step(4'b0000, "burst4_after");

    // Max burst length
    bus.burst_len = 3'd7; bus.start = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 1) bus.start = 1'b0;
      step(fr(i, 1, 1), "burst_max");
    end
    step(4'b0001, "burst_max_done");
    step(4'b0000, "burst_max_after");

    // Abort during period 3 of a 5-period 2/2 burst
    bus.high_cnt = 4'd2; bus.low_cnt = 4'd2; bus.burst_len = 3'd5; bus.start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i == 1) bus.start = 1'b0;
      step(fr(i, 2, 2), "burst_pre_abort");
    end
    bus.en = 1'b0;
    step(4'b0000, "burst_abort");
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) step(4'b0000, "abort_no_relaunch");

    // Reserved mode never launches, even with start
    bus.mode = 2'b10; bus.start = 1'b1;
    step(4'b0000, "reserved_mode");
    step(4'b0000, "reserved_mode_hold");
    bus.start = 1'b0;

    // All-ones phase lengths: period 30
    bus.mode = 2'b00; bus.high_cnt = 4'd15; bus.low_cnt = 4'd15;
    for (int i = 0; i < 62; i++) step(fr(i, 15, 15), "max_phase");

    // Asynchronous reset between edges, mid-HIGH
    bus.high_cnt = 4'd3; bus.low_cnt = 4'd2;
    #2;
    rst_n = 1'b0;
    #1;
    expect_now(4'b0000, "async_reset");
    @(posedge clk);
    #1;
    expect_now(4'b0000, "reset_held");
    #2;
    rst_n = 1'b1;
    #1;
    expect_now(4'b0000, "reset_released");
    for (int i = 0; i < 10; i++) step(fr(i, 3, 2), "post_reset_freerun");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no completion expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
